// File: rtl/pa_fpu_frbus_if.sv
// FPU result-bus handshake bundle between the pipeline control
// (master) and the result-bus arbiter / write-back register (slave).
interface pa_fpu_frbus_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int PREG_WIDTH  = 5,
   parameter int FFLAG_WIDTH = 5
);
   logic                   ctrl_frbus_ex2_wb_req;
   logic                   ctrl_frbus_ex3_wb_req;
   logic                   ctrl_frbus_ex4_wb_req;
   logic [DATA_WIDTH-1:0]  ex2_frbus_data;
   logic [DATA_WIDTH-1:0]  ex3_frbus_data;
   logic [DATA_WIDTH-1:0]  ex4_frbus_data;
   logic [PREG_WIDTH-1:0]  ex2_frbus_preg;
   logic [PREG_WIDTH-1:0]  ex3_frbus_preg;
   logic [PREG_WIDTH-1:0]  ex4_frbus_preg;
   logic [FFLAG_WIDTH-1:0] ex2_frbus_fflags;
   logic [FFLAG_WIDTH-1:0] ex3_frbus_fflags;
   logic [FFLAG_WIDTH-1:0] ex4_frbus_fflags;
   logic                   rf_frbus_wb_ready;
   logic                   frbus_ctrl_ex2_wb_grant;
   logic                   frbus_ctrl_ex3_wb_grant;
   logic                   frbus_ctrl_ex4_wb_grant;
   logic                   frbus_rf_wb_vld;
   logic [DATA_WIDTH-1:0]  frbus_rf_wb_data;
   logic [PREG_WIDTH-1:0]  frbus_rf_wb_preg;
   logic [FFLAG_WIDTH-1:0] frbus_rf_wb_fflags;
   logic                   frbus_fpu_no_op;

   modport master (
      output ctrl_frbus_ex2_wb_req, ctrl_frbus_ex3_wb_req,
             ctrl_frbus_ex4_wb_req,
             ex2_frbus_data, ex3_frbus_data, ex4_frbus_data,
             ex2_frbus_preg, ex3_frbus_preg, ex4_frbus_preg,
             ex2_frbus_fflags, ex3_frbus_fflags, ex4_frbus_fflags,
             rf_frbus_wb_ready,
      input  frbus_ctrl_ex2_wb_grant, frbus_ctrl_ex3_wb_grant,
             frbus_ctrl_ex4_wb_grant,
             frbus_rf_wb_vld, frbus_rf_wb_data, frbus_rf_wb_preg,
             frbus_rf_wb_fflags, frbus_fpu_no_op
   );

   modport slave (
      input  ctrl_frbus_ex2_wb_req, ctrl_frbus_ex3_wb_req,
             ctrl_frbus_ex4_wb_req,
             ex2_frbus_data, ex3_frbus_data, ex4_frbus_data,
             ex2_frbus_preg, ex3_frbus_preg, ex4_frbus_preg,
             ex2_frbus_fflags, ex3_frbus_fflags, ex4_frbus_fflags,
             rf_frbus_wb_ready,
      output frbus_ctrl_ex2_wb_grant, frbus_ctrl_ex3_wb_grant,
             frbus_ctrl_ex4_wb_grant,
             frbus_rf_wb_vld, frbus_rf_wb_data, frbus_rf_wb_preg,
             frbus_rf_wb_fflags, frbus_fpu_no_op
   );
endinterface

// File: rtl/pa_fpu_frbus.sv
// FPU result-bus arbiter: oldest-first grant among EX4/EX3/EX2 and a
// single-entry write-back register with valid/ready toward the FPR file.
module gated_clk_cell (
   input  logic clk_in,
   input  logic global_en,
   input  logic module_en,
   input  logic local_en,
   input  logic external_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);
   logic en_bf_latch;
   logic en_af_latch;

   assign en_bf_latch = (global_en && (module_en || local_en)) || external_en;

   // Enable latch is transparent while the clock is low, so clk_out is glitch-free.
   always_latch begin
      if (!clk_in) en_af_latch = en_bf_latch || pad_yy_icg_scan_en;
   end

   assign clk_out = clk_in && en_af_latch;
endmodule

module pa_fpu_frbus #(
   parameter int DATA_WIDTH  = 64,
   parameter int PREG_WIDTH  = 5,
   parameter int FFLAG_WIDTH = 5
) (
   input  logic forever_cpuclk,
   input  logic cpurst_b,
   input  logic cp0_yy_clk_en,
   input  logic cp0_fpu_icg_en,
   input  logic pad_yy_icg_scan_en,
   pa_fpu_frbus_if.slave bus
);
   logic                   req2, req3, req4;
   logic                   any_req;
   logic                   wb_free;
   logic                   gnt2, gnt3, gnt4;
   logic                   any_gnt;
   logic                   local_en;
   logic                   frbus_clk;
   logic                   wb_vld_q, wb_vld_d;
   logic [DATA_WIDTH-1:0]  wb_data_q, wb_data_d;
   logic [PREG_WIDTH-1:0]  wb_preg_q, wb_preg_d;
   logic [FFLAG_WIDTH-1:0] wb_fflags_q, wb_fflags_d;

   assign req2    = bus.ctrl_frbus_ex2_wb_req;
   assign req3    = bus.ctrl_frbus_ex3_wb_req;
   assign req4    = bus.ctrl_frbus_ex4_wb_req;
   assign any_req = req2 || req3 || req4;

   // Grants are masked during reset so nothing is handed out before the register exists.
   assign wb_free = !wb_vld_q || bus.rf_frbus_wb_ready;
   assign gnt4    = cpurst_b && wb_free && req4;
   assign gnt3    = cpurst_b && wb_free && req3 && !req4;
   assign gnt2    = cpurst_b && wb_free && req2 && !req4 && !req3;
   assign any_gnt = gnt2 || gnt3 || gnt4;

   assign local_en = any_req || wb_vld_q;

   gated_clk_cell x_frbus_gated_clk (
      .clk_in             (forever_cpuclk),
      .global_en          (cp0_yy_clk_en),
      .module_en          (cp0_fpu_icg_en),
      .local_en           (local_en),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (frbus_clk)
   );

   // Next state: load the winner, otherwise hold payload; valid persists only while stalled.
   always_comb begin
      wb_vld_d    = any_gnt || (wb_vld_q && !bus.rf_frbus_wb_ready);
      wb_data_d   = wb_data_q;
      wb_preg_d   = wb_preg_q;
      wb_fflags_d = wb_fflags_q;
      unique case (1'b1)
         gnt4: begin
            wb_data_d   = bus.ex4_frbus_data;
            wb_preg_d   = bus.ex4_frbus_preg;
            wb_fflags_d = bus.ex4_frbus_fflags;
         end
         gnt3: begin
            wb_data_d   = bus.ex3_frbus_data;
            wb_preg_d   = bus.ex3_frbus_preg;
            wb_fflags_d = bus.ex3_frbus_fflags;
         end
         gnt2: begin
            wb_data_d   = bus.ex2_frbus_data;
            wb_preg_d   = bus.ex2_frbus_preg;
            wb_fflags_d = bus.ex2_frbus_fflags;
         end
         default: ;
      endcase
   end

   // Write-back register on the gated clock; async reset drops any held entry.
   always_ff @(posedge frbus_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         wb_vld_q    <= 1'b0;
         wb_data_q   <= '0;
         wb_preg_q   <= '0;
         wb_fflags_q <= '0;
      end else begin
         wb_vld_q    <= wb_vld_d;
         wb_data_q   <= wb_data_d;
         wb_preg_q   <= wb_preg_d;
         wb_fflags_q <= wb_fflags_d;
      end
   end

   assign bus.frbus_ctrl_ex2_wb_grant = gnt2;
   assign bus.frbus_ctrl_ex3_wb_grant = gnt3;
   assign bus.frbus_ctrl_ex4_wb_grant = gnt4;
   assign bus.frbus_rf_wb_vld         = wb_vld_q;
   assign bus.frbus_rf_wb_data        = wb_data_q;
   assign bus.frbus_rf_wb_preg        = wb_preg_q;
   assign bus.frbus_rf_wb_fflags      = wb_fflags_q;
   assign bus.frbus_fpu_no_op         = !cpurst_b || (!wb_vld_q && !any_req);

   a_gnt_onehot0: assert property (
      @(posedge forever_cpuclk) disable iff (!cpurst_b)
      $onehot0({gnt4, gnt3, gnt2}));

   a_no_gnt_stall: assert property (
      @(posedge forever_cpuclk) disable iff (!cpurst_b)
      (wb_vld_q && !bus.rf_frbus_wb_ready) |-> !any_gnt);
endmodule

// File: tb/tb_pa_fpu_frbus.sv
// Directed bench for the FPU result-bus arbiter and write-back register.
// Inputs change 1ns after the rising edge; outputs are read 1-2ns after it.
module tb_pa_fpu_frbus;
   logic clk;
   logic rst_b;
   logic clk_en;
   logic icg_en;
   logic scan_en;
   int   n_cmp;
   int   n_err;

   localparam logic [63:0] D2 = 64'h2222_3333_4444_5555;
   localparam logic [63:0] D3 = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] D4 = 64'hC008_0000_0000_0001;

   pa_fpu_frbus_if #(.DATA_WIDTH(64), .PREG_WIDTH(5), .FFLAG_WIDTH(5)) bus ();

   pa_fpu_frbus #(.DATA_WIDTH(64), .PREG_WIDTH(5), .FFLAG_WIDTH(5)) dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_b),
      .cp0_yy_clk_en      (clk_en),
      .cp0_fpu_icg_en     (icg_en),
      .pad_yy_icg_scan_en (scan_en),
      .bus                (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] gnts();
      return {bus.frbus_ctrl_ex4_wb_grant, bus.frbus_ctrl_ex3_wb_grant,
              bus.frbus_ctrl_ex2_wb_grant};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic r4, input logic r3, input logic r2);
      bus.ctrl_frbus_ex4_wb_req = r4;
      bus.ctrl_frbus_ex3_wb_req = r3;
      bus.ctrl_frbus_ex2_wb_req = r2;
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      set_req(1'b1, 1'b1, 1'b1);
      bus.rf_frbus_wb_ready = 1'b1;
      tick(); tick();
      #1;
      n_cmp++;
      if (gnts() !== 3'b000) begin
         n_err++; $display("FAIL rst_gnt got %b want 000", gnts());
      end
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b0) begin
         n_err++; $display("FAIL rst_vld got %b want 0", bus.frbus_rf_wb_vld);
      end
      n_cmp++;
      if (bus.frbus_fpu_no_op !== 1'b1) begin
         n_err++; $display("FAIL rst_noop got %b want 1", bus.frbus_fpu_no_op);
      end
      n_cmp++;
      if (bus.frbus_rf_wb_data !== 64'd0 || bus.frbus_rf_wb_preg !== 5'd0) begin
         n_err++;
         $display("FAIL rst_payload got %h/%0d want 0/0",
                  bus.frbus_rf_wb_data, bus.frbus_rf_wb_preg);
      end
      tick();
      rst_b = 1'b1;
      #1;
      n_cmp++;
      if (gnts() !== 3'b100) begin
         n_err++; $display("FAIL rst_first_gnt got %b want 100", gnts());
      end
      tick();
      set_req(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b1 || bus.frbus_rf_wb_preg !== 5'd4) begin
         n_err++;
         $display("FAIL rst_first_wb got vld=%b preg=%0d want 1/4",
                  bus.frbus_rf_wb_vld, bus.frbus_rf_wb_preg);
      end
      tick();
   endtask

   task automatic test_contention();
      set_req(1'b1, 1'b1, 1'b1);
      bus.rf_frbus_wb_ready = 1'b1;
      #1;
      n_cmp++;
      if (gnts() !== 3'b100) begin
         n_err++; $display("FAIL cont_g4 got %b want 100", gnts());
      end
      tick();
      set_req(1'b0, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if (gnts() !== 3'b010) begin
         n_err++; $display("FAIL cont_g3 got %b want 010", gnts());
      end
      n_cmp++;
      if (bus.frbus_rf_wb_preg !== 5'd4 || bus.frbus_rf_wb_data !== D4) begin
         n_err++;
         $display("FAIL cont_wb4 got preg=%0d data=%h want 4/%h",
                  bus.frbus_rf_wb_preg, bus.frbus_rf_wb_data, D4);
      end
      tick();
      set_req(1'b0, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (gnts() !== 3'b001) begin
         n_err++; $display("FAIL cont_g2 got %b want 001", gnts());
      end
      n_cmp++;
      if (bus.frbus_rf_wb_preg !== 5'd3 || bus.frbus_rf_wb_data !== D3) begin
         n_err++;
         $display("FAIL cont_wb3 got preg=%0d data=%h want 3/%h",
                  bus.frbus_rf_wb_preg, bus.frbus_rf_wb_data, D3);
      end
      tick();
      set_req(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.frbus_rf_wb_preg !== 5'd2 || bus.frbus_rf_wb_vld !== 1'b1) begin
         n_err++;
         $display("FAIL cont_wb2 got preg=%0d vld=%b want 2/1",
                  bus.frbus_rf_wb_preg, bus.frbus_rf_wb_vld);
      end
      tick();
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b0 || bus.frbus_fpu_no_op !== 1'b1) begin
         n_err++;
         $display("FAIL cont_idle got vld=%b no_op=%b want 0/1",
                  bus.frbus_rf_wb_vld, bus.frbus_fpu_no_op);
      end
   endtask

   task automatic test_backpressure();
      set_req(1'b0, 1'b1, 1'b0);
      bus.rf_frbus_wb_ready = 1'b1;
      tick();
      bus.ex3_frbus_data = 64'h4000_0000_0000_0000;
      bus.rf_frbus_wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (gnts() !== 3'b000) begin
            n_err++; $display("FAIL bp_gnt[%0d] got %b want 000", i, gnts());
         end
         n_cmp++;
         if (bus.frbus_rf_wb_data !== D3 || bus.frbus_rf_wb_vld !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d] got %h vld=%b want %h/1",
                     i, bus.frbus_rf_wb_data, bus.frbus_rf_wb_vld, D3);
         end
         tick();
      end
      bus.rf_frbus_wb_ready = 1'b1;
      #1;
      n_cmp++;
      if (gnts() !== 3'b010) begin
         n_err++; $display("FAIL bp_release got %b want 010", gnts());
      end
      tick();
      set_req(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.frbus_rf_wb_data !== 64'h4000_0000_0000_0000 ||
          bus.frbus_rf_wb_vld !== 1'b1) begin
         n_err++;
         $display("FAIL bp_new got %h vld=%b want 4000000000000000/1",
                  bus.frbus_rf_wb_data, bus.frbus_rf_wb_vld);
      end
      tick();
      bus.ex3_frbus_data = D3;
   endtask

   task automatic test_back_to_back();
      set_req(1'b0, 1'b0, 1'b1);
      bus.rf_frbus_wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.ex2_frbus_data = 64'h100 + 64'(i);
         #1;
         n_cmp++;
         if (gnts() !== 3'b001) begin
            n_err++; $display("FAIL b2b_gnt[%0d] got %b want 001", i, gnts());
         end
         tick();
         n_cmp++;
         if (bus.frbus_rf_wb_vld !== 1'b1 ||
             bus.frbus_rf_wb_data !== 64'h100 + 64'(i)) begin
            n_err++;
            $display("FAIL b2b_wb[%0d] got vld=%b data=%h want 1/%h",
                     i, bus.frbus_rf_wb_vld, bus.frbus_rf_wb_data,
                     64'h100 + 64'(i));
         end
      end
      set_req(1'b0, 1'b0, 1'b0);
      bus.ex2_frbus_data = D2;
      tick();
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b0) begin
         n_err++; $display("FAIL b2b_end got vld=%b want 0", bus.frbus_rf_wb_vld);
      end
   endtask

   task automatic test_drain();
      set_req(1'b1, 1'b0, 1'b0);
      bus.rf_frbus_wb_ready = 1'b1;
      #1;
      n_cmp++;
      if (gnts() !== 3'b100 || bus.frbus_fpu_no_op !== 1'b0) begin
         n_err++;
         $display("FAIL drain_gnt got %b no_op=%b want 100/0",
                  gnts(), bus.frbus_fpu_no_op);
      end
      tick();
      set_req(1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b1 || bus.frbus_rf_wb_fflags !== 5'b00001) begin
         n_err++;
         $display("FAIL drain_nx got vld=%b ff=%b want 1/00001",
                  bus.frbus_rf_wb_vld, bus.frbus_rf_wb_fflags);
      end
      n_cmp++;
      if (bus.frbus_fpu_no_op !== 1'b0) begin
         n_err++; $display("FAIL drain_busy got no_op=%b want 0", bus.frbus_fpu_no_op);
      end
      tick();
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b0 || bus.frbus_fpu_no_op !== 1'b1) begin
         n_err++;
         $display("FAIL drain_idle got vld=%b no_op=%b want 0/1",
                  bus.frbus_rf_wb_vld, bus.frbus_fpu_no_op);
      end
   endtask

   task automatic test_async_reset();
      set_req(1'b1, 1'b0, 1'b0);
      bus.rf_frbus_wb_ready = 1'b1;
      tick();
      set_req(1'b0, 1'b0, 1'b0);
      bus.rf_frbus_wb_ready = 1'b0;
      tick();
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b1 || bus.frbus_rf_wb_data !== D4) begin
         n_err++;
         $display("FAIL arst_pre got vld=%b data=%h want 1/%h",
                  bus.frbus_rf_wb_vld, bus.frbus_rf_wb_data, D4);
      end
      #1;
      rst_b = 1'b0;
      #1;
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b0 || bus.frbus_rf_wb_data !== 64'd0) begin
         n_err++;
         $display("FAIL arst_now got vld=%b data=%h want 0/0",
                  bus.frbus_rf_wb_vld, bus.frbus_rf_wb_data);
      end
      tick();
      rst_b = 1'b1;
      tick(); tick();
      n_cmp++;
      if (bus.frbus_rf_wb_vld !== 1'b0 || bus.frbus_rf_wb_data !== 64'd0 ||
          bus.frbus_fpu_no_op !== 1'b1) begin
         n_err++;
         $display("FAIL arst_after got vld=%b data=%h no_op=%b want 0/0/1",
                  bus.frbus_rf_wb_vld, bus.frbus_rf_wb_data, bus.frbus_fpu_no_op);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      rst_b   = 1'b0;
      clk_en  = 1'b1;
      icg_en  = 1'b0;
      scan_en = 1'b0;
      set_req(1'b0, 1'b0, 1'b0);
      bus.rf_frbus_wb_ready = 1'b0;
      bus.ex2_frbus_data    = D2;
      bus.ex3_frbus_data    = D3;
      bus.ex4_frbus_data    = D4;
      bus.ex2_frbus_preg    = 5'd2;
      bus.ex3_frbus_preg    = 5'd3;
      bus.ex4_frbus_preg    = 5'd4;
      bus.ex2_frbus_fflags  = 5'b00010;
      bus.ex3_frbus_fflags  = 5'b00000;
      bus.ex4_frbus_fflags  = 5'b00001;
      test_reset();
      test_contention();
      test_backpressure();
      test_back_to_back();
      test_drain();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
